// File: rtl/dcache_arbiter_pkg.sv
// dcache_arbiter_pkg: shared state, request record and index helper for the data-cache arbiter
package dcache_arbiter_pkg;
  typedef enum logic {IDLE, LOCKED} dc_arb_state_t;
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
  } dc_req_t;
  function automatic int next_idx(int g, int n);
    return (g + 1 == n) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/dcache_arbiter_if.sv
// dcache_arbiter_if: requester-side and cache-side signals of the shared data-cache port
interface dcache_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req_rd;
  logic [NREQ-1:0]       req_wr;
  logic [NREQ-1:0][31:0] req_addr;
  logic [NREQ-1:0][31:0] req_wr_data;
  logic [NREQ-1:0][3:0]  req_wr_be;
  logic [NREQ-1:0]       req_waitrequest;
  logic [31:0]           req_rd_data;
  logic                  cache_rd;
  logic                  cache_wr;
  logic [31:0]           cache_addr;
  logic [31:0]           cache_wr_data;
  logic [3:0]            cache_wr_be;
  logic [31:0]           cache_data;
  logic                  cache_waitrequest;
  logic [1:0]            grant_idx;
  modport slave (
    input  req_rd, req_wr, req_addr, req_wr_data, req_wr_be, cache_data, cache_waitrequest,
    output req_waitrequest, req_rd_data, cache_rd, cache_wr, cache_addr, cache_wr_data,
           cache_wr_be, grant_idx
  );
  modport master (
    output req_rd, req_wr, req_addr, req_wr_data, req_wr_be, cache_data, cache_waitrequest,
    input  req_waitrequest, req_rd_data, cache_rd, cache_wr, cache_addr, cache_wr_data,
           cache_wr_be, grant_idx
  );
endinterface

// File: rtl/dcache_arbiter_rr_pick.sv
// rr_pick: first set mask bit at or after ptr, wrapping to the lowest set bit
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic          hi_v;
  logic [IW-1:0] hi_i;
  logic [IW-1:0] lo_i;
  always_comb begin
    hi_v = 1'b0;
    hi_i = '0;
    lo_i = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (mask[j]) begin
        if (IW'(j) >= ptr) begin
          hi_v = 1'b1;
          hi_i = IW'(j);
        end
        lo_i = IW'(j);
      end
    end
    valid = |mask;
    idx   = hi_v ? hi_i : lo_i;
  end
endmodule

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: round-robin sharing of one data-cache port, locked to the owner while the cache stalls
module dcache_arbiter
  import dcache_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic clock,
  input logic reset,
  dcache_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  dc_arb_state_t   state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   g;
  logic [NREQ-1:0] active;
  logic            pick_valid;
  logic            gv;
  logic            done;
  dc_req_t         reqs [NREQ];
  dc_req_t         cmd;
  // a simultaneous read and write is issued as a read only
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign reqs[i] = '{
      rd:      bus.req_rd[i],
      wr:      bus.req_wr[i] & ~bus.req_rd[i],
      addr:    bus.req_addr[i],
      wr_data: bus.req_wr_data[i],
      wr_be:   (bus.req_wr[i] & ~bus.req_rd[i]) ? bus.req_wr_be[i] : 4'h0
    };
  end
  assign active = bus.req_rd | bus.req_wr;
  rr_pick #(.N(NREQ)) u_pick (
    .mask(active),
    .ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  always_comb begin
    g    = (state == LOCKED) ? owner : pick_idx;
    gv   = !reset && ((state == LOCKED) ? active[owner] : pick_valid);
    cmd  = gv ? reqs[g] : '0;
    done = gv && !bus.cache_waitrequest;
  end
  assign bus.cache_rd        = cmd.rd;
  assign bus.cache_wr        = cmd.wr;
  assign bus.cache_addr      = cmd.addr;
  assign bus.cache_wr_data   = cmd.wr_data;
  assign bus.cache_wr_be     = cmd.wr_be;
  assign bus.req_rd_data     = bus.cache_data;
  assign bus.grant_idx       = 2'(g);
  assign bus.req_waitrequest = active & ~(done ? (NREQ'(1) << g) : {NREQ{1'b0}});
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (state == IDLE) begin
      if (done) rr_ptr <= IW'(next_idx(int'(g), NREQ));
      else if (gv) begin
        state <= LOCKED;
        owner <= g;
      end
    end else if (!active[owner] || done) begin
      state <= IDLE;
      if (done) rr_ptr <= IW'(next_idx(int'(g), NREQ));
    end
  end
  a_owner_hold: assert property (@(posedge clock) disable iff (reset) (state == LOCKED) |-> active[owner]);
  a_rd_wr_excl: assert property (@(posedge clock) disable iff (reset) !(|(bus.req_rd & bus.req_wr)));
  a_single_cmd: assert property (@(posedge clock) !(bus.cache_rd && bus.cache_wr));
endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed vector table on a 2-port arbiter plus random protocol traffic on a 4-port one
module tb_dcache_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  dcache_arbiter_if #(.NREQ(2)) b2 ();
  dcache_arbiter_if #(.NREQ(4)) b4 ();
  dcache_arbiter #(.NREQ(2)) dut2 (.clock(clk), .reset(rst), .bus(b2));
  dcache_arbiter #(.NREQ(4)) dut4 (.clock(clk), .reset(rst), .bus(b4));
  typedef struct {
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        cw;
    logic        crd;
    logic        cwr;
    logic [31:0] addr;
    logic [1:0]  wt;
    logic [1:0]  g;
  } vec_t;
  vec_t tv [22];
  task automatic chk(input string n, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", n, row, act, exp);
    end
  endtask
  initial begin
    logic [31:0] cdata;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    int          g0_cnt;
    logic [3:0]  act4;
    logic [3:0]  comp4;
    logic [3:0]  done4;
    logic [3:0]  exp_comp;
    int          wcnt [4];
    logic        r;
    tv[0]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,   2'b01, 2'd0};
    tv[1]  = '{1'b0, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 32'h100, 2'b10, 2'd0};
    tv[2]  = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 32'h200, 2'b00, 2'd1};
    tv[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,   2'b00, 2'd0};
    for (int k = 4; k < 12; k++)
      tv[k] = (k % 2 == 0) ? '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 32'h100, 2'b10, 2'd0}
                           : '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 32'h200, 2'b01, 2'd1};
    tv[12] = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200, 2'b10, 2'd1};
    tv[13] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200, 2'b11, 2'd1};
    tv[14] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200, 2'b11, 2'd1};
    tv[15] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 32'h200, 2'b01, 2'd1};
    tv[16] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 32'h100, 2'b10, 2'd0};
    tv[17] = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200, 2'b10, 2'd1};
    tv[18] = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0,   2'b11, 2'd0};
    tv[19] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 32'h100, 2'b10, 2'd0};
    tv[20] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 32'h200, 2'b01, 2'd1};
    tv[21] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,   2'b00, 2'd0};
    b2.req_rd = '0;
    b2.req_wr = '0;
    b2.req_addr[0] = 32'h100;
    b2.req_addr[1] = 32'h200;
    b2.req_wr_data[0] = 32'h1111_0000;
    b2.req_wr_data[1] = 32'hDEAD_BEEF;
    b2.req_wr_be[0] = 4'hF;
    b2.req_wr_be[1] = 4'b0011;
    b2.cache_waitrequest = 1'b0;
    b2.cache_data = '0;
    b4.req_rd = '0;
    b4.req_wr = '0;
    b4.req_addr = '0;
    b4.req_wr_data = '0;
    b4.req_wr_be = '0;
    b4.cache_waitrequest = 1'b0;
    b4.cache_data = '0;
    repeat (2) @(posedge clk);
    g0_cnt = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk);
      #1;
      cdata = 32'hC0DE_0000 + 32'(k);
      rst = tv[k].rst;
      b2.req_rd = tv[k].rd;
      b2.req_wr = tv[k].wr;
      b2.cache_waitrequest = tv[k].cw;
      b2.cache_data = cdata;
      @(negedge clk);
      chk("cache_rd", k, 32'(b2.cache_rd), 32'(tv[k].crd));
      chk("cache_wr", k, 32'(b2.cache_wr), 32'(tv[k].cwr));
      chk("cache_addr", k, b2.cache_addr, tv[k].addr);
      chk("req_waitrequest", k, 32'(b2.req_waitrequest), 32'(tv[k].wt));
      if (tv[k].crd || tv[k].cwr) chk("grant_idx", k, 32'(b2.grant_idx), 32'(tv[k].g));
      exp_wd = (tv[k].g == 2'd1) ? 32'hDEAD_BEEF : 32'h1111_0000;
      exp_be = (tv[k].g == 2'd1) ? 4'b0011 : 4'hF;
      if (tv[k].cwr) begin
        chk("cache_wr_data", k, b2.cache_wr_data, exp_wd);
        chk("cache_wr_be", k, 32'(b2.cache_wr_be), 32'(exp_be));
      end
      if (!tv[k].crd && !tv[k].cwr) begin
        chk("idle_wr_data", k, b2.cache_wr_data, 32'h0);
        chk("idle_wr_be", k, 32'(b2.cache_wr_be), 32'h0);
      end
      if (tv[k].crd && !tv[k].cw) chk("req_rd_data", k, b2.req_rd_data, cdata);
      if (k >= 4 && k < 12 && b2.cache_wr && b2.grant_idx == 2'd0) g0_cnt++;
    end
    chk("share_req0", 0, 32'(g0_cnt), 32'd4);
    rst = 1'b0;
    b2.req_rd = '0;
    b2.req_wr = '0;
    done4 = '0;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!(b4.req_rd[i] | b4.req_wr[i]) || done4[i]) begin
          if ($urandom_range(1) == 0) begin
            r = 1'($urandom_range(1));
            b4.req_rd[i] = r;
            b4.req_wr[i] = !r;
            b4.req_addr[i] = $urandom;
            b4.req_wr_data[i] = $urandom;
            b4.req_wr_be[i] = 4'($urandom);
          end else begin
            b4.req_rd[i] = 1'b0;
            b4.req_wr[i] = 1'b0;
          end
        end
      end
      b4.cache_waitrequest = ($urandom_range(2) == 0);
      b4.cache_data = $urandom;
      @(negedge clk);
      act4 = b4.req_rd | b4.req_wr;
      comp4 = act4 & ~b4.req_waitrequest;
      exp_comp = ((b4.cache_rd || b4.cache_wr) && !b4.cache_waitrequest) ? (4'b1 << b4.grant_idx) : 4'b0;
      chk("rand_double_cmd", c, 32'(b4.cache_rd && b4.cache_wr), 32'h0);
      chk("rand_completion", c, 32'(comp4), 32'(exp_comp));
      chk("rand_cmd_present", c, 32'(b4.cache_rd || b4.cache_wr), 32'(|act4));
      if (b4.cache_rd || b4.cache_wr) begin
        chk("rand_addr", c, b4.cache_addr, b4.req_addr[b4.grant_idx]);
        chk("rand_kind", c, 32'(b4.cache_rd), 32'(b4.req_rd[b4.grant_idx]));
      end
      for (int i = 0; i < 4; i++) begin
        if (comp4[i] || !act4[i]) wcnt[i] = 0;
        else if (|comp4) wcnt[i]++;
        chk("rand_fairness", c, 32'(wcnt[i] > 3), 32'h0);
      end
      done4 = comp4;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
